// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared bus constants, master indices and arbiter state type
package bus_pkg;

  localparam int BUS_W = 32;

  // Fixed master slots on the shared bus; new masters take the next index.
  localparam int BUS_ICACHE = 0;
  localparam int BUS_DCACHE = 1;
  localparam int BUS_DMA    = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/bus_rr_arbiter_if.sv
// rtl/bus_rr_arbiter_if.sv - shared system bus signal bundle between masters and the arbiter
// Ports (by modport):
//   slave  : arbiter side - takes requests, master buses and bus_ready;
//            drives grants, muxed bus, owner/busy/timeout_err
//   master : requester side - the mirror image
interface bus_rr_arbiter_if
  import bus_pkg::*;
#(
  parameter int NREQ = 8
);

  logic [NREQ-1:0]       bus_req;
  logic [NREQ-1:0]       bus_ack;
  logic [BUS_W*NREQ-1:0] m_addr;
  logic [BUS_W*NREQ-1:0] m_wdata;
  logic [NREQ-1:0]       m_rd;
  logic [NREQ-1:0]       m_wr;
  logic [BUS_W-1:0]      bus_addr;
  logic [BUS_W-1:0]      bus_wdata;
  logic                  bus_rd;
  logic                  bus_wr;
  logic                  bus_ready;
  logic [2:0]            owner;
  logic                  busy;
  logic                  timeout_err;

  modport slave (
    input  bus_req, m_addr, m_wdata, m_rd, m_wr, bus_ready,
    output bus_ack, bus_addr, bus_wdata, bus_rd, bus_wr, owner, busy, timeout_err
  );

  modport master (
    output bus_req, m_addr, m_wdata, m_rd, m_wr, bus_ready,
    input  bus_ack, bus_addr, bus_wdata, bus_rd, bus_wr, owner, busy, timeout_err
  );

endinterface

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - rotating-priority encoder: first set request searching upward from last+1
// Ports:
//   req   in  NREQ  eligible requests
//   last  in  3     index of the most recent winner
//   valid out 1     any request set
//   idx   out 3     winning index (upper bits 0 when NREQ<8)
module rr_pick #(
  parameter int NREQ = 8
) (
  input  logic [NREQ-1:0] req,
  input  logic [2:0]      last,
  output logic            valid,
  output logic [2:0]      idx
);

  int w_best;

  // Each requester's distance from last+1 (mod NREQ); the smallest distance wins.
  always_comb begin
    valid  = 1'b0;
    idx    = '0;
    w_best = NREQ;
    for (int i = 0; i < NREQ; i++) begin
      if (req[i] && (((i - int'(last) - 1 + 2 * NREQ) % NREQ) < w_best)) begin
        w_best = (i - int'(last) - 1 + 2 * NREQ) % NREQ;
        valid  = 1'b1;
        idx    = 3'(i);
      end
    end
  end

endmodule

// File: rtl/bus_rr_arbiter.sv
// rtl/bus_rr_arbiter.sv - registered round-robin bus arbiter with owner mux and grant watchdog
// Ports:
//   clk   in  system clock
//   Nrst  in  asynchronous active-low reset
//   bif   slave modport of bus_rr_arbiter_if (requests, master buses, grants, muxed bus,
//         owner/busy status, one-cycle timeout_err pulse)
module bus_rr_arbiter
  import bus_pkg::*;
#(
  parameter int NREQ    = 8,
  parameter int TIMEOUT = 255
) (
  input logic             clk,
  input logic             Nrst,
  bus_rr_arbiter_if.slave bif
);

  arb_state_e       r_state;
  logic [NREQ-1:0]  r_ack;
  logic [NREQ-1:0]  r_mask;
  logic [2:0]       r_owner;
  logic [2:0]       r_last;
  logic             r_busy;
  logic             r_terr;
  logic [15:0]      r_wdog;

  logic             w_valid;
  logic [2:0]       w_idx;
  logic [NREQ-1:0]  w_elig;
  logic [NREQ-1:0]  w_win_oh;
  logic [NREQ-1:0]  w_own_oh;
  logic             w_own_req;
  logic             w_own_rd;
  logic             w_own_wr;
  logic [BUS_W-1:0] w_own_addr;
  logic [BUS_W-1:0] w_own_wdata;
  logic [15:0]      w_wdog_inc;
  logic             w_timeout;

  // Revoked masters stay out of arbitration until they drop their request.
  assign w_elig = bif.bus_req & ~r_mask;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (w_elig),
    .last  (r_last),
    .valid (w_valid),
    .idx   (w_idx)
  );

  always_comb begin
    w_win_oh    = '0;
    w_own_oh    = '0;
    w_own_req   = 1'b0;
    w_own_rd    = 1'b0;
    w_own_wr    = 1'b0;
    w_own_addr  = '0;
    w_own_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_idx == 3'(i)) begin
        w_win_oh[i] = 1'b1;
      end
      if (r_owner == 3'(i)) begin
        w_own_oh[i] = 1'b1;
        w_own_req   = bif.bus_req[i];
        w_own_rd    = bif.m_rd[i];
        w_own_wr    = bif.m_wr[i];
        w_own_addr  = bif.m_addr[BUS_W*i +: BUS_W];
        w_own_wdata = bif.m_wdata[BUS_W*i +: BUS_W];
      end
    end
  end

  assign w_wdog_inc = r_wdog + 16'd1;
  assign w_timeout  = !bif.bus_ready && (w_wdog_inc == 16'(TIMEOUT));

  always_ff @(posedge clk or negedge Nrst) begin
    if (!Nrst) begin
      r_state <= ST_IDLE;
      r_ack   <= '0;
      r_mask  <= '0;
      r_owner <= '0;
      r_last  <= 3'(NREQ - 1);
      r_busy  <= 1'b0;
      r_terr  <= 1'b0;
      r_wdog  <= '0;
    end else begin
      r_terr <= 1'b0;
      r_mask <= r_mask & bif.bus_req;
      case (r_state)
        ST_IDLE: begin
          if (w_valid) begin
            r_ack   <= w_win_oh;
            r_owner <= w_idx;
            r_last  <= w_idx;
            r_busy  <= 1'b1;
            r_state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          // A request drop takes priority over the watchdog on the same edge.
          if (!w_own_req) begin
            r_ack   <= '0;
            r_busy  <= 1'b0;
            r_wdog  <= '0;
            r_state <= ST_RELEASE;
          end else if (w_timeout) begin
            r_ack   <= '0;
            r_busy  <= 1'b0;
            r_wdog  <= '0;
            r_terr  <= 1'b1;
            r_mask  <= (r_mask & bif.bus_req) | w_own_oh;
            r_state <= ST_RELEASE;
          end else begin
            r_wdog <= bif.bus_ready ? 16'd0 : w_wdog_inc;
          end
        end
        ST_RELEASE: begin
          r_wdog  <= '0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bif.bus_ack     = r_ack;
  assign bif.owner       = r_owner;
  assign bif.busy        = r_busy;
  assign bif.timeout_err = r_terr;
  assign bif.bus_addr    = r_busy ? w_own_addr  : '0;
  assign bif.bus_wdata   = r_busy ? w_own_wdata : '0;
  assign bif.bus_rd      = r_busy & w_own_rd;
  assign bif.bus_wr      = r_busy & w_own_wr;

endmodule
